// File: rtl/branch_resolve_unit_if.sv
// Handshake and status bundle between the decode/fetch side and the
// branch resolve unit. The master modport is the pipeline side and the
// slave modport is the branch resolve unit.
interface branch_resolve_unit_if;
    // Decode-side branch issue
    logic        bru_in_valid;
    logic        bru_in_ready;
    logic [63:0] bru_in_pc;
    logic [63:0] bru_in_imm;
    logic [6:0]  bru_in_opcode;
    logic        bru_in_pred_taken;
    logic        bru_cmp_result;

    // Fetch-side prediction lookup
    logic [63:0] bru_lookup_pc;
    logic        bru_lookup_taken;

    // Redirect back to fetch
    logic        bru_redirect_valid;
    logic        bru_redirect_ready;
    logic [63:0] bru_redirect_pc;
    logic        bru_flush;

    // Statistics
    logic [31:0] bru_branch_count;
    logic [31:0] bru_mispredict_count;

    modport master (
        output bru_in_valid, bru_in_pc, bru_in_imm, bru_in_opcode,
               bru_in_pred_taken, bru_cmp_result, bru_lookup_pc,
               bru_redirect_ready,
        input  bru_in_ready, bru_lookup_taken, bru_redirect_valid,
               bru_redirect_pc, bru_flush, bru_branch_count,
               bru_mispredict_count
    );

    modport slave (
        input  bru_in_valid, bru_in_pc, bru_in_imm, bru_in_opcode,
               bru_in_pred_taken, bru_cmp_result, bru_lookup_pc,
               bru_redirect_ready,
        output bru_in_ready, bru_lookup_taken, bru_redirect_valid,
               bru_redirect_pc, bru_flush, bru_branch_count,
               bru_mispredict_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: accepts one branch at a time from decode, resolves
// its direction and target, trains a table of 2-bit counters, and on a
// mispredict redirects fetch and then flushes the front end for a fixed
// number of cycles.
module branch_resolve_unit #(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                   clk,
    input logic                   reset,
    branch_resolve_unit_if.slave  bru
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE,
        RESOLVE,
        REDIRECT,
        FLUSH
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] imm_q, imm_d;
    logic [6:0]  opcode_q, opcode_d;
    logic        pred_q, pred_d;
    logic        cmp_q, cmp_d;
    logic [63:0] target_q, target_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;
    logic [1:0]  bht_q [BHT_ENTRIES];
    logic [1:0]  bht_d [BHT_ENTRIES];

    logic             is_br;
    logic             taken;
    logic             mispredict;
    logic [63:0]      target_calc;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lookup_idx;
    logic             unused_lookup_bits;

    // Resolution of the latched branch; only consumed in RESOLVE.
    always_comb begin
        is_br       = (opcode_q == OPC_BRANCH);
        taken       = is_br & cmp_q;
        target_calc = taken ? (pc_q + imm_q) : (pc_q + 64'd4);
        mispredict  = (taken != pred_q);
        upd_idx     = pc_q[IDX_W+1:2];
        lookup_idx  = bru.bru_lookup_pc[IDX_W+1:2];
    end

    // Only the index bits of the lookup PC select a counter.
    assign unused_lookup_bits = ^{bru.bru_lookup_pc[63:IDX_W+2], bru.bru_lookup_pc[1:0]};

    // Next-state, latch, table training and counter logic.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the
        // case below can leave a signal unassigned and infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        imm_d         = imm_q;
        opcode_d      = opcode_q;
        pred_d        = pred_q;
        cmp_d         = cmp_q;
        target_d      = target_q;
        flush_cnt_d   = flush_cnt_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        bht_d         = bht_q;

        case (state_q)
            IDLE: begin
                if (bru.bru_in_valid) begin
                    pc_d     = bru.bru_in_pc;
                    imm_d    = bru.bru_in_imm;
                    opcode_d = bru.bru_in_opcode;
                    pred_d   = bru.bru_in_pred_taken;
                    cmp_d    = bru.bru_cmp_result;
                    state_d  = RESOLVE;
                end
            end

            RESOLVE: begin
                target_d = target_calc;
                if (is_br) begin
                    if (taken) begin
                        if (bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
                    end else begin
                        if (bht_q[upd_idx] != 2'b00) bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
                    end
                    if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_d = branch_cnt_q + 32'd1;
                end
                state_d = mispredict ? REDIRECT : IDLE;
            end

            REDIRECT: begin
                if (bru.bru_redirect_ready) begin
                    if (mispred_cnt_q != 32'hFFFF_FFFF) mispred_cnt_d = mispred_cnt_q + 32'd1;
                    flush_cnt_d = 4'(FLUSH_CYCLES);
                    state_d     = FLUSH;
                end
            end

            FLUSH: begin
                if (flush_cnt_q <= 4'd1) begin
                    flush_cnt_d = 4'd0;
                    state_d     = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State register; reset wins over any handshake in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            imm_q         <= '0;
            opcode_q      <= '0;
            pred_q        <= 1'b0;
            cmp_q         <= 1'b0;
            target_q      <= '0;
            flush_cnt_q   <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            // NOTE: the table is built from flops, not a RAM, so it can be
            // (and must be) reset to weakly not-taken on every entry.
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value.
            state_q       <= state_d;
            pc_q          <= pc_d;
            imm_q         <= imm_d;
            opcode_q      <= opcode_d;
            pred_q        <= pred_d;
            cmp_q         <= cmp_d;
            target_q      <= target_d;
            flush_cnt_q   <= flush_cnt_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            bht_q         <= bht_d;
        end
    end

    // Outputs decoded from the registered state; lookup reads the
    // registered table so a same-cycle update is not forwarded.
    always_comb begin
        bru.bru_in_ready         = (state_q == IDLE);
        bru.bru_redirect_valid   = (state_q == REDIRECT);
        bru.bru_redirect_pc      = (state_q == REDIRECT) ? target_q : 64'd0;
        bru.bru_flush            = (state_q == FLUSH);
        bru.bru_lookup_taken     = bht_q[lookup_idx][1];
        bru.bru_branch_count     = branch_cnt_q;
        bru.bru_mispredict_count = mispred_cnt_q;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 16, number of 2-bit predictor counters (power of 2, 2..256).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush is held after a redirect (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port bru_in_valid  input  1  decode stage presents a resolved-operand branch.
REQ-006 SHALL have port bru_in_ready  output  1  unit accepts a branch this cycle.
REQ-007 SHALL have port bru_in_pc  input  64  PC of the branch.
REQ-008 SHALL have port bru_in_imm  input  64  sign-extended B-type offset.
REQ-009 SHALL have port bru_in_opcode  input  7  instruction opcode.
REQ-010 SHALL have port bru_in_pred_taken  input  1  prediction used by fetch.
REQ-011 SHALL have port bru_cmp_result  input  1  branch comparator result for the presented operands.
REQ-012 SHALL have port bru_lookup_pc  input  64  fetch PC for prediction lookup.
REQ-013 SHALL have port bru_lookup_taken  output  1  combinational prediction: MSB of the indexed counter.
REQ-014 SHALL have port bru_redirect_valid  output  1  fetch must restart at bru_redirect_pc.
REQ-015 SHALL have port bru_redirect_ready  input  1  fetch accepts the redirect.
REQ-016 SHALL have port bru_redirect_pc  output  64  corrected next PC.
REQ-017 SHALL have port bru_flush  output  1  kill younger instructions in fetch/decode.
REQ-018 SHALL have port bru_branch_count  output  32  resolved B-type branches.
REQ-019 SHALL have port bru_mispredict_count  output  32  redirects issued.

Function
REQ-020 FSM states SHALL be IDLE, RESOLVE, REDIRECT, FLUSH; bru_in_ready SHALL be 1 only in IDLE.
REQ-021 In IDLE, on bru_in_valid=1: latch pc, imm, opcode, pred_taken and bru_cmp_result, then go to RESOLVE; otherwise stay in IDLE.
REQ-022 In RESOLVE (exactly 1 cycle): is_br = (opcode==7'b1100011); taken = is_br & latched cmp; target = taken ? pc+imm : pc+4, both computed modulo 2^64 (wrap-around, no overflow flag).
REQ-023 In RESOLVE: mispredict = (taken != pred_taken); next state is REDIRECT if mispredict, else IDLE.
REQ-024 In RESOLVE, if is_br: update counter at index pc[log2(BHT_ENTRIES)+1:2] with saturating +1 if taken, -1 if not taken (range 0..3), and increment bru_branch_count.
REQ-025 A non-B-type opcode SHALL NOT update the BHT or bru_branch_count; it resolves as not-taken (redirect to pc+4 if pred_taken=1).
REQ-026 In REDIRECT: bru_redirect_valid=1 and bru_redirect_pc=target, both held stable until bru_redirect_ready=1; on that handshake cycle increment bru_mispredict_count and go to FLUSH.
REQ-027 In FLUSH: bru_flush=1 for exactly FLUSH_CYCLES consecutive cycles (down-counter), then return to IDLE; bru_flush=0 in all other states.
REQ-028 Both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-029 Lookup index = bru_lookup_pc[log2(BHT_ENTRIES)+1:2]; a lookup to the entry being updated in the same cycle SHALL return the pre-update value.
REQ-030 bru_redirect_pc SHALL be 0 whenever bru_redirect_valid=0.
REQ-031 Minimum latency: a correctly predicted branch accepted at cycle N SHALL allow the next acceptance at cycle N+2.

Reset
REQ-032 Reset SHALL override every state and have priority over any handshake, including mid-REDIRECT or mid-FLUSH.
REQ-033 After reset: state IDLE, bru_in_ready=1, bru_redirect_valid=0, bru_redirect_pc=0, bru_flush=0, both counters 0, all BHT counters 2'b01 (weakly not-taken, bru_lookup_taken=0).

Verification
REQ-034 Reset, then BEQ pc=0x1000 imm=0x40 cmp=1 pred=0 -> RESOLVE, redirect_valid with pc 0x1040; ready=1 -> flush for 2 cycles; branch_count=1, mispredict_count=1, counter[0] becomes 2'b10.
REQ-035 BNE pc=0x2004 imm=-8 cmp=0 pred=0 -> no redirect, no flush, branch_count increments; next branch accepted 2 cycles after the first.
REQ-036 Redirect with bru_redirect_ready low for 5 cycles -> redirect_valid and redirect_pc=target stable all 5 cycles; mispredict_count increments only on the accept cycle.
REQ-037 Three taken branches at pc=0x0 -> counter goes 01->10->11->11 (saturates); lookup_pc=0x0 -> taken=1; lookup during 3rd update returns the old value 1.
REQ-038 pc=0xFFFF_FFFF_FFFF_FFFC, not-taken, pred=1 -> redirect_pc=0x0 (wrap-around).
REQ-039 Assert reset during REDIRECT and during FLUSH -> next cycle IDLE, outputs and BHT at their reset values.
